mdu_sched: RTL
==============

# mdu_sched

Multiply/divide scheduler and HI/LO register owner for the MIPS pipeline. It takes MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the EX stage. It runs an iterative 32-step shift-add multiplier and a restoring divider, and writes HI/LO on completion. It exposes `busy` so ID/EX can stall MFHI/MFLO and any further HI/LO-class instruction until results are architecturally visible.

## Interface
Parameters: none.
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- req_valid  input  1  EX presents an HI/LO-class op
- req_ready  output  1  scheduler can accept this cycle; equals `state==IDLE`, independent of `req_valid`
- req_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved
- req_src1  input  32  rs value (dividend / multiplicand / MT data)
- req_src2  input  32  rt value (divisor / multiplier)
- flush  input  1  abort any in-flight op, ignore request this cycle
- busy  output  1  op in flight; `~req_ready`
- done  output  1  one-cycle pulse, new HI/LO visible this cycle
- hi  output  32  architectural HI
- lo  output  32  architectural LO

## Operation
- Accept: `req_valid && req_ready && !flush` at a rising edge.
- States: IDLE, MUL, DIV. Reset → IDLE with hi=0, lo=0, done=0, busy=0, iteration counter=0.
- MTHI/MTLO: hi (or lo) <= req_src1 at the accept edge. State stays IDLE. done=1 the next cycle.
- Reserved ops 6/7: accepted, no state change, no done.
- MULT/MULTU → MUL. Operands latched as 32-bit magnitudes; for signed ops, a negative operand is two's-complemented. Sign flag = src1[31]^src2[31], signed only.
  - 32 iterations of shift-add into a 64-bit accumulator.
  - On the final iteration, {hi,lo} <= sign ? −acc : acc.
- DIV/DIVU → DIV. Uses magnitudes as above.
  - 32 restoring steps: shift {rem,quot} left 1, trial-subtract divisor from rem, keep the result and set the quotient bit if it is non-negative. Use a 33-bit trial.
  - Final: lo = quotient negated if signs differ; hi = remainder negated if src1 was negative (signed only).
- Divide by zero uses no special path; the algorithm result is architectural:
  - DIVU: lo=FFFFFFFF, hi=src1.
  - DIV: lo = src1[31] ? 00000001 : FFFFFFFF; hi=src1.
- DIV 80000000 / FFFFFFFF: lo=80000000, hi=00000000. No trap.
- flush:
  - In MUL/DIV: the next edge goes to IDLE, hi/lo unchanged, no done.
  - In IDLE: suppresses accept.
  - Flush on the final iteration edge wins, so there is no write.
- hi/lo only change on an MT accept edge or a completion edge.

## Timing
- MT ops: accept edge E0. New value visible from cycle 1. done high in cycle 1. req_ready stays high.
- Iterative MUL/DIV: accept edge E0.
  - busy=1 in cycles 1..32.
  - The counter runs 31→0. The completion write happens at edge E32.
  - In cycle 33: busy=0, done=1, new hi/lo visible, next request acceptable.
  - Back-to-back throughput is one long op per 33 cycles.
- done is registered. Within one cycle, a new accept may coincide with done high.
- hi/lo are undefined-for-use while busy. ID must stall MFHI/MFLO while `busy`. The scheduler does not forward.
- reset mid-operation: hi=lo=0, IDLE, no done, next cycle.

## Configuration
- `MDU_FAST_MULT_EN` defined: MULT/MULTU use a single-cycle 32×32 multiplier.
  - {hi,lo} are written at the accept edge. State stays IDLE and busy never rises. done is high in cycle 1, same as MT ops.
  - DIV/DIVU are unchanged.
- Undefined: MULT/MULTU use the 32-iteration MUL state with 33-cycle latency as above.
- Port list is identical in both builds.

## Test plan
- Reset, then MTHI 12345678 and MTLO 9ABCDEF0 on consecutive cycles → hi=12345678, lo=9ABCDEF0. Two done pulses. busy never high.
- MULT FFFFFFFE × 00000003 → {hi,lo}=FFFFFFFF_FFFFFFFA.
  - Done in cycle 33 with busy high for cycles 1..32, or in cycle 1 with `MDU_FAST_MULT_EN`.
  - MULTU on the same operands → hi=00000002, lo=FFFFFFFA.
- DIV FFFFFFF9 (−7) / 00000002 → lo=FFFFFFFD, hi=FFFFFFFF. DIVU 7/2 → lo=3, hi=1. Each done exactly at cycle 33.
- Divide by zero: DIVU 00000005/0 → lo=FFFFFFFF, hi=5. DIV 80000000/FFFFFFFF → lo=80000000, hi=0.
- Flush during DIV (cycle 10, and separately at the final-iteration cycle 32) → hi/lo keep prior values, no done, req_ready high the next cycle.
- req_valid held high with a new DIVU while busy → not accepted until cycle 33. Accepted at edge E33 with done=1 in the same cycle.

Source files
------------

// File: rtl/mdu_sched.sv
// HI/LO owner for the MIPS pipeline: iterative shift-add multiplier and restoring divider.
// Optional build macro MDU_FAST_MULT_EN selects a single-cycle MULT/MULTU path.
module mdu_sched (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int unsigned W  = 32;
    localparam int unsigned W2 = 64;
    localparam int unsigned CW = 5;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [W2-1:0] prod;
    logic [W-1:0]  mcand;
    logic [W-1:0]  rem;
    logic [W-1:0]  quot;
    logic [W-1:0]  divisor;
    logic          neg_q;
    logic          neg_r;

    logic          accept;
    logic          neg1, neg2;
    logic [W-1:0]  mag1, mag2;
    logic [W:0]    mul_sum;
    logic [W2-1:0] mul_next;
    logic [W:0]    div_shift;
    logic [W:0]    div_trial;
    logic          div_ge;
    logic [W-1:0]  rem_next;
    logic [W-1:0]  quot_next;
`ifdef MDU_FAST_MULT_EN
    logic [W2-1:0] fast_prod;
`endif

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready && !flush;

    // Operand magnitudes and one step of each iterative datapath
    always_comb begin
        neg1      = ((req_op == OP_MULT) || (req_op == OP_DIV)) && req_src1[W-1];
        neg2      = ((req_op == OP_MULT) || (req_op == OP_DIV)) && req_src2[W-1];
        mag1      = neg1 ? W'(-req_src1) : req_src1;
        mag2      = neg2 ? W'(-req_src2) : req_src2;
        mul_sum   = {1'b0, prod[W2-1:W]} + (prod[0] ? {1'b0, mcand} : (W+1)'(0));
        mul_next  = {mul_sum, prod[W-1:1]};
        div_shift = {rem, quot[W-1]};
        div_trial = div_shift - {1'b0, divisor};
        div_ge    = !div_trial[W];
        rem_next  = div_ge ? div_trial[W-1:0] : div_shift[W-1:0];
        quot_next = {quot[W-2:0], div_ge};
`ifdef MDU_FAST_MULT_EN
        fast_prod = W2'(mag1) * W2'(mag2);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            prod    <= '0;
            mcand   <= '0;
            rem     <= '0;
            quot    <= '0;
            divisor <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (req_op)
                            OP_MTHI: begin
                                hi   <= req_src1;
                                done <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo   <= req_src1;
                                done <= 1'b1;
                            end
                            OP_MULT, OP_MULTU: begin
`ifdef MDU_FAST_MULT_EN
                                {hi, lo} <= (neg1 ^ neg2) ? W2'(-fast_prod) : fast_prod;
                                done     <= 1'b1;
`else
                                state <= MUL;
                                prod  <= {W'(0), mag2};
                                mcand <= mag1;
                                neg_q <= neg1 ^ neg2;
                                cnt   <= CW'(W - 1);
`endif
                            end
                            OP_DIV, OP_DIVU: begin
                                state   <= DIV;
                                rem     <= '0;
                                quot    <= mag1;
                                divisor <= mag2;
                                neg_q   <= neg1 ^ neg2;
                                neg_r   <= neg1;
                                cnt     <= CW'(W - 1);
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        prod <= mul_next;
                        cnt  <= cnt - CW'(1);
                        if (cnt == '0) begin
                            {hi, lo} <= neg_q ? W2'(-mul_next) : mul_next;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                DIV: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        rem  <= rem_next;
                        quot <= quot_next;
                        cnt  <= cnt - CW'(1);
                        if (cnt == '0) begin
                            lo    <= neg_q ? W'(-quot_next) : quot_next;
                            hi    <= neg_r ? W'(-rem_next) : rem_next;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
